// File: rtl/keypad_emu_4x4.sv
// keypad_emu_4x4
//
// Plays the keyboard side of a 4x4 matrix keypad for a keypad scanner.
// A host queues 8-bit key codes. Each code is one-hot row in [7:4], with bit 7
// being row 0, and one-hot column in [3:0], with bit 3 being column 0.
// Each queued key is "pressed" by pulling its column low while the scanner
// strobes its row. The press lasts for HOLD_SCANS full scanner sweeps. The key
// is then released for GAP_SCANS sweeps before the next key is taken.
//
// Ports
//   i_clk        clock; all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_row[3:0]   scanner row strobes, active-low, one row low at a time
//   o_col[3:0]   column lines back to the scanner, active-low, registered
//   i_key_valid  host offers i_key_code this cycle
//   i_key_code   key code, row nibble [7:4], column nibble [3:0]
//   o_key_ready  queue not full; push = i_key_valid & o_key_ready
//   o_busy       FSM not idle or queue not empty
//   o_err        one-cycle pulse after a pushed code is rejected as malformed
//
// Build option
//   KEYPAD_EMU_SYNC_EN  when defined, i_row passes through a two-flop
//                       synchronizer, giving 3 clk of row-to-col latency.
//                       Otherwise i_row is registered once, giving 2 clk of
//                       latency; that build suits a scanner that runs on i_clk.
module keypad_emu_4x4 #(
  parameter int HOLD_SCANS = 8,
  parameter int GAP_SCANS  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  input  logic       i_key_valid,
  input  logic [7:0] i_key_code,
  output logic       o_key_ready,
  output logic       o_busy,
  output logic       o_err
);

  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  ST_IDLE    = 2'd0;
  localparam logic [1:0]  ST_PRESS   = 2'd1;
  localparam logic [1:0]  ST_RELEASE = 2'd2;
  localparam logic [7:0]  HOLD_CNT = 8'(HOLD_SCANS);
  localparam logic [7:0]  GAP_CNT  = 8'(GAP_SCANS);
  localparam logic [AW:0] PTR_ONE  = (AW + 1)'(1);

  // Row sampling.
  logic [3:0] r_row_sync;
`ifdef KEYPAD_EMU_SYNC_EN
  logic [3:0] r_row_meta;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row_meta <= 4'b1111;
      r_row_sync <= 4'b1111;
    end else begin
      r_row_meta <= i_row;
      r_row_sync <= r_row_meta;
    end
  end
`else
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_row_sync <= 4'b1111;
    else          r_row_sync <= i_row;
  end
`endif

  // A sweep starts when the sampled row enters the row-0 strobe.
  logic [3:0] r_row_prev;
  logic       w_sweep;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_row_prev <= 4'b1111;
    else          r_row_prev <= r_row_sync;
  end
  assign w_sweep = (r_row_sync == 4'b1110) && (r_row_prev != 4'b1110);

  // Key queue. Pointers carry one extra wrap bit to tell full from empty.
  logic [7:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  logic        w_empty, w_full, w_code_ok, w_push_try, w_push, w_pop;
  logic [1:0]  r_state, w_state_next;
  logic [7:0]  r_cnt, w_cnt_next;
  logic [7:0]  r_cur_code, w_cur_next;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_code_ok  = $onehot(i_key_code[7:4]) && $onehot(i_key_code[3:0]);
  assign w_push_try = i_key_valid && !w_full;
  assign w_push     = w_push_try && w_code_ok;
  assign w_pop      = (r_state == ST_IDLE) && !w_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_key_code;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // The pop can land mid-sweep. In PRESS the first sweep start only closes
  // that partial sweep, so the counter must already sit at HOLD_CNT when a
  // sweep starts to end the press. RELEASE is always entered on a sweep start,
  // so it ends as the counter reaches GAP_CNT.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cur_next   = r_cur_code;
    case (r_state)
      ST_IDLE: begin
        if (w_pop) begin
          w_cur_next   = r_mem[r_rd_ptr[AW-1:0]];
          w_cnt_next   = 8'd0;
          w_state_next = ST_PRESS;
        end
      end
      ST_PRESS: begin
        if (w_sweep) begin
          if (r_cnt == HOLD_CNT) begin
            w_cnt_next   = 8'd0;
            w_state_next = ST_RELEASE;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      ST_RELEASE: begin
        if (w_sweep) begin
          if (r_cnt + 8'd1 == GAP_CNT) begin
            w_cnt_next   = 8'd0;
            w_state_next = ST_IDLE;
          end else begin
            w_cnt_next = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Code nibbles put index 0 in the MSB, while pins put index 0 in bit 0, so
  // both nibbles are reversed onto the pins. Queued codes are one-hot, so the
  // strobe is always a single-low pattern and never matches a malformed row.
  // The col register uses the next state, so a press starts in the cycle
  // after the pop and stops on the sweep start that ends it.
  logic [3:0] w_strobe, w_col_drive, r_col;
  assign w_strobe    = ~{w_cur_next[4], w_cur_next[5], w_cur_next[6], w_cur_next[7]};
  assign w_col_drive = ~{w_cur_next[0], w_cur_next[1], w_cur_next[2], w_cur_next[3]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 8'd0;
      r_cur_code <= 8'd0;
      r_col      <= 4'b1111;
      o_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_cur_code <= w_cur_next;
      r_col      <= ((w_state_next == ST_PRESS) && (r_row_sync == w_strobe)) ?
                    w_col_drive : 4'b1111;
      o_err      <= w_push_try && !w_code_ok;
    end
  end

  assign o_col       = r_col;
  assign o_key_ready = !w_full;
  assign o_busy      = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_keypad_emu_4x4.sv
module tb_keypad_emu_4x4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row = 4'b1110;
  logic [3:0] col;
  logic       key_valid = 1'b0;
  logic [7:0] key_code = 8'h00;
  logic       key_ready, busy, err;

`ifdef KEYPAD_EMU_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int checks = 0;
  int errors = 0;

  bit scan_en = 1'b1;
  int scan_ph = 0;
  int scan_tick = 0;
  logic [3:0] hist [0:2];

  keypad_emu_4x4 dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_row(row), .o_col(col),
    .i_key_valid(key_valid), .i_key_code(key_code),
    .o_key_ready(key_ready), .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  // Model scanner: each row strobe lasts 11 clk, so one sweep is 44 clk.
  function automatic logic [3:0] pat(input int p);
    case (p)
      0: pat = 4'b1110;
      1: pat = 4'b1101;
      2: pat = 4'b1011;
      default: pat = 4'b0111;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scan_en) begin
        row = pat(scan_ph);
        scan_tick++;
        if (scan_tick == 11) begin
          scan_tick = 0;
          scan_ph = (scan_ph + 1) % 4;
        end
      end else begin
        row = 4'b1111;
      end
    end
  end

  // Row history captured on the clock. The col seen at a negedge sample
  // answers to hist[LAT-1].
  always @(posedge clk) begin
    hist[2] <= hist[1];
    hist[1] <= hist[0];
    hist[0] <= row;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    bit ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (scan_ph == p && scan_tick == 5) begin
        ok = 1'b1;
        break;
      end
    end
    chk("phase_sync", 32'(ok), 32'd1);
  endtask

  task automatic push(input logic [7:0] c);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code = c;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  // Watch one key until busy drops.
  // low:  samples with the expected col under the expected row
  // bad:  any other non-idle col
  // win:  number of press windows
  // tail: samples from the last press sample to the first busy-low sample
  task automatic observe(input logic [3:0] er, input logic [3:0] ec, input int budget,
                         output int low, output int bad, output int win,
                         output int tail, output bit tmo);
    int last_low = 0;
    logic [3:0] prev = 4'b1111;
    low = 0; bad = 0; win = 0; tail = -1; tmo = 1'b1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (col != 4'b1111) begin
        if (col == ec && hist[LAT-1] == er) low++;
        else bad++;
        if (prev == 4'b1111) win++;
        last_low = n;
      end
      prev = col;
      if (!busy) begin
        tail = n - last_low;
        tmo = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int low, bad, win, tail;
    bit tmo;
    logic [7:0] codes [5];
    logic [7:0] exp_pairs [5];
    logic [7:0] seen [$];
    int rdy_low;
    bit done;
    int w;
    logic [3:0] pv;
    int stall_bad;

    codes = '{8'b1000_0100, 8'b0100_0010, 8'b0010_0001, 8'b0001_1000, 8'b0100_0100};
    // {row strobe, col pattern}, worked out by hand from the codes above
    exp_pairs = '{8'hED, 8'hDB, 8'hB7, 8'h7E, 8'hDD};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_col", 32'(col), 32'hF);
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_col", 32'(col), 32'hF);

    // Single key, row 0 / col 0, popped during the row-2 strobe:
    // 8 row-0 windows of 11 clk, then 33 + 4*44 + 1 samples until busy drops
    wait_phase(2);
    push(8'b1000_1000);
    @(negedge clk);
    chk("single_busy_rise", 32'(busy), 32'd1);
    observe(4'b1110, 4'b1110, 800, low, bad, win, tail, tmo);
    chk("single_timeout", 32'(tmo), 32'd0);
    chk("single_low_cycles", 32'(low), 32'd88);
    chk("single_bad_cycles", 32'(bad), 32'd0);
    chk("single_windows", 32'(win), 32'd8);
    chk("single_gap_tail", 32'(tail), 32'd210);

    // Malformed codes are rejected
    push(8'b1100_0100);
    @(negedge clk);
    chk("inv_err_pulse", 32'(err), 32'd1);
    chk("inv_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("inv_err_clear", 32'(err), 32'd0);
    push(8'b0000_1000);
    @(negedge clk);
    chk("inv_row_zero_err", 32'(err), 32'd1);
    repeat (60) @(negedge clk);
    chk("inv_col_idle", 32'(col), 32'hF);
    chk("inv_busy_end", 32'(busy), 32'd0);

    // Back-pressure: five pushes back to back, then a sixth while full
    wait_phase(2);
    @(posedge clk);
    #1;
    key_valid = 1'b1;
    key_code = codes[0];
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      key_code = (i < 4) ? codes[i+1] : 8'b1000_1000;
      @(negedge clk);
      chk($sformatf("bp_ready_after_push%0d", i + 1), 32'(key_ready), (i < 4) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    @(negedge clk);
    chk("bp_sixth_refused", 32'(key_ready), 32'd0);
    rdy_low = 0;
    done = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (!key_ready) rdy_low++;
      if (col != 4'b1111) begin
        if (seen.size() == 0 || seen[$] != {hist[LAT-1], col}) begin
          seen.push_back({hist[LAT-1], col});
          if (seen.size() == 2) chk("bp_ready_before_key2", 32'(key_ready), 32'd1);
        end
      end
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("bp_timeout", 32'(done), 32'd1);
    chk("bp_ready_held_low", 32'(rdy_low > 300), 32'd1);
    chk("bp_key_count", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_key%0d", i), 32'((i < seen.size()) ? seen[i] : 8'h00), 32'(exp_pairs[i]));
    end

    // Row 3 / col 3, popped during the row-0 strobe: the partial sweep
    // already holds one row-3 window, giving 9 windows in total
    wait_phase(0);
    push(8'b0001_0001);
    observe(4'b0111, 4'b0111, 800, low, bad, win, tail, tmo);
    chk("r3_timeout", 32'(tmo), 32'd0);
    chk("r3_low_cycles", 32'(low), 32'd99);
    chk("r3_bad_cycles", 32'(bad), 32'd0);
    chk("r3_gap_tail", 32'(tail), 32'd177);

    // Reset mid-press, with further keys queued
    wait_phase(2);
    push(8'b1000_1000);
    push(8'b0100_0010);
    push(8'b0010_0001);
    done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (col == 4'b1110) begin
        done = 1'b1;
        break;
      end
    end
    chk("rstmid_press_seen", 32'(done), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_col", 32'(col), 32'hF);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ready", 32'(key_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (col != 4'b1111 || busy) bad++;
    end
    chk("rstmid_queue_lost", 32'(bad), 32'd0);
    chk("rstmid_ready_after", 32'(key_ready), 32'd1);

    // Stalled scanner during PRESS: stop after 3 windows, hold 1000 clk,
    // then the remaining 5 windows follow
    wait_phase(2);
    push(8'b1000_1000);
    w = 0;
    pv = 4'b1111;
    done = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (col != 4'b1111 && pv == 4'b1111) w++;
      if (col == 4'b1111 && pv != 4'b1111 && w == 3) begin
        done = 1'b1;
        break;
      end
      pv = col;
    end
    chk("stall_pre_windows", 32'(done), 32'd1);
    scan_en = 1'b0;
    stall_bad = 0;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk);
      if (col != 4'b1111 || !busy) stall_bad++;
    end
    chk("stall_hold", 32'(stall_bad), 32'd0);
    scan_en = 1'b1;
    observe(4'b1110, 4'b1110, 800, low, bad, win, tail, tmo);
    chk("stall_timeout", 32'(tmo), 32'd0);
    chk("stall_rest_windows", 32'(win), 32'd5);
    chk("stall_rest_low", 32'(low), 32'd55);
    chk("stall_rest_bad", 32'(bad), 32'd0);
    chk("stall_gap_tail", 32'(tail), 32'd210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
